// File: rtl/add_share_sched.sv
// Round-robin scheduler sharing one W-bit adder between two stream channels.
// Each channel owns a 1-deep result register and a RUN/DONE end-of-stream state.
module add_share_sched #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] a0_d,
  input  logic         a0_e,
  input  logic         a0_v,
  output logic         a0_b,
  input  logic [W-1:0] b0_d,
  input  logic         b0_e,
  input  logic         b0_v,
  output logic         b0_b,
  input  logic [W-1:0] a1_d,
  input  logic         a1_e,
  input  logic         a1_v,
  output logic         a1_b,
  input  logic [W-1:0] b1_d,
  input  logic         b1_e,
  input  logic         b1_v,
  output logic         b1_b,
  output logic [W-1:0] s0_d,
  output logic         s0_e,
  output logic         s0_v,
  input  logic         s0_b,
  output logic [W-1:0] s1_d,
  output logic         s1_e,
  output logic         s1_v,
  input  logic         s1_b,
  output logic         done0,
  output logic         done1,
  output logic         mismatch0,
  output logic         mismatch1
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_DONE = 1'b1;

  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] x, input logic [W-1:0] y);
    return x + y;
  endfunction

  logic [W-1:0] a_d [2];
  logic [W-1:0] b_d [2];
  logic [1:0]   a_e, a_v, b_e, b_v, s_b;

  assign a_d[0] = a0_d;
  assign a_d[1] = a1_d;
  assign b_d[0] = b0_d;
  assign b_d[1] = b1_d;
  assign a_e    = {a1_e, a0_e};
  assign a_v    = {a1_v, a0_v};
  assign b_e    = {b1_e, b0_e};
  assign b_v    = {b1_v, b0_v};
  assign s_b    = {s1_b, s0_b};

  logic [0:0]   state_q [2];
  logic [0:0]   state_d [2];
  logic [W-1:0] res_d_q [2];
  logic [W-1:0] res_d_d [2];
  logic [1:0]   full_q, full_d;
  logic [1:0]   res_e_q, res_e_d;
  logic [1:0]   done_q, done_d;
  logic [1:0]   mis_q, mis_d;
  logic         prio_q, prio_d;

  logic [1:0]   free, pair, req_add, req_eos, req_drop, req;
  logic [1:0]   gnt, take_a, take_b;

  // Request classification; nothing may be consumed while reset is high.
  always_comb begin
    free     = '0;
    pair     = '0;
    req_add  = '0;
    req_eos  = '0;
    req_drop = '0;
    for (int n = 0; n < 2; n++) begin
      free[n]     = ~full_q[n] | ~s_b[n];
      pair[n]     = a_v[n] & b_v[n] & (state_q[n] == ST_RUN) & ~reset;
      req_add[n]  = pair[n] & ~a_e[n] & ~b_e[n] & free[n];
      req_eos[n]  = pair[n] &  a_e[n] &  b_e[n] & free[n];
      req_drop[n] = pair[n] & (a_e[n] ^ b_e[n]);
    end
  end

  assign req = req_add | req_eos | req_drop;

  // prio_q names the channel that wins when both request.
  assign gnt[0] = req[0] & (~req[1] | ~prio_q);
  assign gnt[1] = req[1] & (~req[0] |  prio_q);

  always_comb begin
    take_a = '0;
    take_b = '0;
    for (int n = 0; n < 2; n++) begin
      take_a[n] = gnt[n] & (req_add[n] | req_eos[n] | (req_drop[n] & ~a_e[n]));
      take_b[n] = gnt[n] & (req_add[n] | req_eos[n] | (req_drop[n] & ~b_e[n]));
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt[0])      prio_d = 1'b1;
    else if (gnt[1]) prio_d = 1'b0;

    full_d  = full_q;
    res_e_d = res_e_q;
    done_d  = done_q;
    mis_d   = mis_q;
    for (int n = 0; n < 2; n++) begin
      state_d[n] = state_q[n];
      res_d_d[n] = res_d_q[n];
      // A reload wins over a drain so back-to-back tokens keep s_v high.
      if (gnt[n] & req_add[n]) begin
        full_d[n]  = 1'b1;
        res_d_d[n] = wrap_add(a_d[n], b_d[n]);
        res_e_d[n] = 1'b0;
      end else if (gnt[n] & req_eos[n]) begin
        full_d[n]  = 1'b1;
        res_d_d[n] = '0;
        res_e_d[n] = 1'b1;
        state_d[n] = ST_DONE;
      end else if (full_q[n] & ~s_b[n]) begin
        full_d[n] = 1'b0;
      end
      if (gnt[n] & req_drop[n]) mis_d[n] = 1'b1;
      if (full_q[n] & res_e_q[n] & ~s_b[n]) done_d[n] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q[0] <= ST_RUN;
      state_q[1] <= ST_RUN;
      res_d_q[0] <= '0;
      res_d_q[1] <= '0;
      full_q     <= '0;
      res_e_q    <= '0;
      done_q     <= '0;
      mis_q      <= '0;
      prio_q     <= 1'b0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      res_d_q[0] <= res_d_d[0];
      res_d_q[1] <= res_d_d[1];
      full_q     <= full_d;
      res_e_q    <= res_e_d;
      done_q     <= done_d;
      mis_q      <= mis_d;
      prio_q     <= prio_d;
    end
  end

  assign a0_b      = ~take_a[0];
  assign b0_b      = ~take_b[0];
  assign a1_b      = ~take_a[1];
  assign b1_b      = ~take_b[1];
  assign s0_d      = res_d_q[0];
  assign s1_d      = res_d_q[1];
  assign s0_e      = res_e_q[0];
  assign s1_e      = res_e_q[1];
  assign s0_v      = full_q[0];
  assign s1_v      = full_q[1];
  assign done0     = done_q[0];
  assign done1     = done_q[1];
  assign mismatch0 = mis_q[0];
  assign mismatch1 = mis_q[1];

endmodule

// File: tb/tb_add_share_sched.sv
// Scenario bench for add_share_sched: per-feature tasks plus a result scoreboard.
module tb_add_share_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] a_d [2];
  logic [15:0] b_d [2];
  logic [15:0] s_d [2];
  logic [1:0]  a_e, a_v, b_e, b_v, s_b;
  logic [1:0]  a_b, b_b, s_e, s_v, done, mis;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] q0 [$];
  logic [16:0] q1 [$];

  add_share_sched #(.W(16)) dut (
    .clock(clock), .reset(reset),
    .a0_d(a_d[0]), .a0_e(a_e[0]), .a0_v(a_v[0]), .a0_b(a_b[0]),
    .b0_d(b_d[0]), .b0_e(b_e[0]), .b0_v(b_v[0]), .b0_b(b_b[0]),
    .a1_d(a_d[1]), .a1_e(a_e[1]), .a1_v(a_v[1]), .a1_b(a_b[1]),
    .b1_d(b_d[1]), .b1_e(b_e[1]), .b1_v(b_v[1]), .b1_b(b_b[1]),
    .s0_d(s_d[0]), .s0_e(s_e[0]), .s0_v(s_v[0]), .s0_b(s_b[0]),
    .s1_d(s_d[1]), .s1_e(s_e[1]), .s1_v(s_v[1]), .s1_b(s_b[1]),
    .done0(done[0]), .done1(done[1]),
    .mismatch0(mis[0]), .mismatch1(mis[1])
  );

  initial forever #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    a_v = '0; b_v = '0; a_e = '0; b_e = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    step();
    reset = 1'b0;
  endtask

  // Pushes expected tokens on operand transfer, pops them on result transfer.
  task automatic sb_monitor();
    logic [16:0] exp_tok;
    logic [15:0] sum;
    forever begin
      @(negedge clock);
      if (reset) begin
        q0.delete();
        q1.delete();
      end else begin
        for (int n = 0; n < 2; n++) begin
          if (s_v[n] && !s_b[n]) begin
            n_checks++;
            if ((n == 0 ? q0.size() : q1.size()) == 0) begin
              n_fail++;
              $display("FAIL sb_ch%0d: unexpected token e=%0b d=%h, none expected", n, s_e[n], s_d[n]);
            end else begin
              exp_tok = (n == 0) ? q0.pop_front() : q1.pop_front();
              if ({s_e[n], s_d[n]} !== exp_tok) begin
                n_fail++;
                $display("FAIL sb_ch%0d: got e=%0b d=%h, expected e=%0b d=%h",
                         n, s_e[n], s_d[n], exp_tok[16], exp_tok[15:0]);
              end
            end
          end
          if (a_v[n] && b_v[n] && !a_b[n] && !b_b[n]) begin
            sum = a_d[n] + b_d[n];
            exp_tok = (a_e[n] && b_e[n]) ? {1'b1, 16'h0000} : {1'b0, sum};
            if (n == 0) q0.push_back(exp_tok);
            else        q1.push_back(exp_tok);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    s_b = '0;
    a_d[0] = 16'h0001; b_d[0] = 16'h0002; a_d[1] = 16'h0; b_d[1] = 16'h0;
    step();
    step();
    a_v[0] = 1'b1; b_v[0] = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({a_b, b_b} !== 4'b1111) begin
      n_fail++; $display("FAIL reset_bp: got a_b=%b b_b=%b, expected 11/11", a_b, b_b);
    end
    step();
    idle();
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({s_v, s_e, done, mis} !== 8'h00) begin
      n_fail++; $display("FAIL reset_flags: got v=%b e=%b done=%b mis=%b, expected all 0", s_v, s_e, done, mis);
    end
    n_checks++;
    if (s_d[0] !== 16'h0 || s_d[1] !== 16'h0) begin
      n_fail++; $display("FAIL reset_data: got s0_d=%h s1_d=%h, expected 0000", s_d[0], s_d[1]);
    end
    step();
  endtask

  task automatic test_single_add();
    s_b = '0;
    a_d[0] = 16'h0003; b_d[0] = 16'h0004; a_v[0] = 1'b1; b_v[0] = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({a_b[0], b_b[0]} !== 2'b00) begin
      n_fail++; $display("FAIL add_take: got a0_b/b0_b=%b, expected 00", {a_b[0], b_b[0]});
    end
    step();
    a_d[0] = 16'hFFFF; b_d[0] = 16'h0002;
    @(negedge clock);
    n_checks++;
    if (s_v[0] !== 1'b1 || s_d[0] !== 16'h0007) begin
      n_fail++; $display("FAIL add_latency: got v=%b d=%h, expected v=1 d=0007", s_v[0], s_d[0]);
    end
    step();
    idle();
    @(negedge clock);
    n_checks++;
    if (s_v[0] !== 1'b1 || s_d[0] !== 16'h0001) begin
      n_fail++; $display("FAIL add_wrap: got v=%b d=%h, expected v=1 d=0001", s_v[0], s_d[0]);
    end
    step();
    step();
  endtask

  task automatic test_contention();
    logic [1:0] obs, expg;
    do_reset();
    s_b = '0;
    a_v = 2'b11; b_v = 2'b11;
    for (int k = 0; k < 8; k++) begin
      a_d[0] = 16'($urandom); b_d[0] = 16'($urandom);
      a_d[1] = 16'($urandom); b_d[1] = 16'($urandom);
      @(negedge clock);
      obs  = {~a_b[1] & ~b_b[1], ~a_b[0] & ~b_b[0]};
      expg = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++;
      if (obs !== expg) begin
        n_fail++; $display("FAIL contend_gnt[%0d]: got {g1,g0}=%b, expected %b", k, obs, expg);
      end
      n_checks++;
      if (s_v[0] !== ((k % 2) == 1)) begin
        n_fail++; $display("FAIL contend_rate[%0d]: got s0_v=%b, expected %0d", k, s_v[0], k % 2);
      end
      step();
    end
    idle();
    step();
    step();
  endtask

  task automatic test_back_pressure();
    s_b = 2'b01;
    a_d[0] = 16'h0008; b_d[0] = 16'h0008; a_v[0] = 1'b1; b_v[0] = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({a_b[0], b_b[0]} !== 2'b00) begin
      n_fail++; $display("FAIL bp_load: got a0_b/b0_b=%b, expected 00", {a_b[0], b_b[0]});
    end
    step();
    a_d[0] = 16'h0001; b_d[0] = 16'h0002;
    a_v[1] = 1'b1; b_v[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_d[1] = 16'($urandom); b_d[1] = 16'($urandom);
      @(negedge clock);
      n_checks++;
      if (s_v[0] !== 1'b1 || s_d[0] !== 16'h0010) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%h, expected v=1 d=0010", k, s_v[0], s_d[0]);
      end
      n_checks++;
      if ({a_b[0], b_b[0]} !== 2'b11) begin
        n_fail++; $display("FAIL bp_block0[%0d]: got a0_b/b0_b=%b, expected 11", k, {a_b[0], b_b[0]});
      end
      n_checks++;
      if ({a_b[1], b_b[1]} !== 2'b00) begin
        n_fail++; $display("FAIL bp_ch1[%0d]: got a1_b/b1_b=%b, expected 00", k, {a_b[1], b_b[1]});
      end
      step();
    end
    s_b[0] = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({a_b[0], b_b[0], a_b[1], b_b[1]} !== 4'b0011) begin
      n_fail++; $display("FAIL bp_release: got a0b,b0b,a1b,b1b=%b, expected 0011",
                         {a_b[0], b_b[0], a_b[1], b_b[1]});
    end
    step();
    idle();
    @(negedge clock);
    n_checks++;
    if (s_v[0] !== 1'b1 || s_d[0] !== 16'h0003) begin
      n_fail++; $display("FAIL bp_reload: got v=%b d=%h, expected v=1 d=0003", s_v[0], s_d[0]);
    end
    step();
    step();
  endtask

  task automatic test_eos();
    s_b = '0;
    a_e[0] = 1'b1; b_e[0] = 1'b1; a_v[0] = 1'b1; b_v[0] = 1'b1; a_d[0] = 16'hAAAA;
    @(negedge clock);
    n_checks++;
    if ({a_b[0], b_b[0]} !== 2'b00) begin
      n_fail++; $display("FAIL eos_take: got a0_b/b0_b=%b, expected 00", {a_b[0], b_b[0]});
    end
    step();
    a_e[0] = 1'b0; b_e[0] = 1'b0; a_d[0] = 16'h0001; b_d[0] = 16'h0001;
    @(negedge clock);
    n_checks++;
    if ({s_v[0], s_e[0], done[0]} !== 3'b110 || s_d[0] !== 16'h0) begin
      n_fail++; $display("FAIL eos_out: got v=%b e=%b done=%b d=%h, expected 1 1 0 0000",
                         s_v[0], s_e[0], done[0], s_d[0]);
    end
    n_checks++;
    if ({a_b[0], b_b[0]} !== 2'b11) begin
      n_fail++; $display("FAIL eos_block: got a0_b/b0_b=%b, expected 11", {a_b[0], b_b[0]});
    end
    step();
    a_v[1] = 1'b1; b_v[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_d[1] = 16'($urandom); b_d[1] = 16'($urandom);
      @(negedge clock);
      n_checks++;
      if (done[0] !== 1'b1 || s_v[0] !== 1'b0) begin
        n_fail++; $display("FAIL eos_done[%0d]: got done0=%b s0_v=%b, expected 1 0", k, done[0], s_v[0]);
      end
      n_checks++;
      if ({a_b[0], b_b[0], a_b[1], b_b[1]} !== 4'b1100) begin
        n_fail++; $display("FAIL eos_ch1[%0d]: got a0b,b0b,a1b,b1b=%b, expected 1100",
                           k, {a_b[0], b_b[0], a_b[1], b_b[1]});
      end
      step();
    end
    idle();
    step();
    step();
  endtask

  task automatic test_mismatch();
    s_b = '0;
    a_e[1] = 1'b1; a_v[1] = 1'b1; a_d[1] = 16'h1234;
    b_e[1] = 1'b0; b_v[1] = 1'b1; b_d[1] = 16'h0005;
    @(negedge clock);
    n_checks++;
    if ({a_b[1], b_b[1], mis[1]} !== 3'b100) begin
      n_fail++; $display("FAIL mm_drop: got a1_b,b1_b,mis1=%b, expected 100", {a_b[1], b_b[1], mis[1]});
    end
    step();
    b_e[1] = 1'b1;
    @(negedge clock);
    n_checks++;
    if (mis[1] !== 1'b1 || s_v[1] !== 1'b0) begin
      n_fail++; $display("FAIL mm_flag: got mis1=%b s1_v=%b, expected 1 0", mis[1], s_v[1]);
    end
    n_checks++;
    if ({a_b[1], b_b[1]} !== 2'b00) begin
      n_fail++; $display("FAIL mm_eos_take: got a1_b/b1_b=%b, expected 00", {a_b[1], b_b[1]});
    end
    step();
    idle();
    @(negedge clock);
    n_checks++;
    if ({s_v[1], s_e[1]} !== 2'b11 || s_d[1] !== 16'h0) begin
      n_fail++; $display("FAIL mm_eos_out: got v=%b e=%b d=%h, expected 1 1 0000", s_v[1], s_e[1], s_d[1]);
    end
    step();
    @(negedge clock);
    n_checks++;
    if ({done[1], s_v[1], mis[1]} !== 3'b101) begin
      n_fail++; $display("FAIL mm_done: got done1,s1_v,mis1=%b, expected 101", {done[1], s_v[1], mis[1]});
    end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    s_b = 2'b01;
    a_d[0] = 16'h0020; b_d[0] = 16'h0001; a_v[0] = 1'b1; b_v[0] = 1'b1;
    step();
    a_d[1] = 16'h0100; b_d[1] = 16'h0200; a_v[1] = 1'b1; b_v[1] = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({a_b, b_b} !== 4'b1111) begin
      n_fail++; $display("FAIL rmid_noconsume: got a_b=%b b_b=%b, expected 11/11", a_b, b_b);
    end
    step();
    reset = 1'b0;
    s_b = '0;
    @(negedge clock);
    n_checks++;
    if ({s_v, s_e, done, mis} !== 8'h00) begin
      n_fail++; $display("FAIL rmid_flags: got v=%b e=%b done=%b mis=%b, expected all 0", s_v, s_e, done, mis);
    end
    n_checks++;
    if ({a_b[0], b_b[0], a_b[1], b_b[1]} !== 4'b0011) begin
      n_fail++; $display("FAIL rmid_ptr: got a0b,b0b,a1b,b1b=%b, expected 0011",
                         {a_b[0], b_b[0], a_b[1], b_b[1]});
    end
    step();
    idle();
    step();
    step();
  endtask

  task automatic test_drain();
    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) step();
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: got %0d/%0d tokens outstanding, expected 0/0", q0.size(), q1.size());
    end
  endtask

  initial begin
    idle();
    s_b = '0;
    fork
      sb_monitor();
    join_none
    test_reset();
    test_single_add();
    test_contention();
    test_back_pressure();
    test_eos();
    test_mismatch();
    test_reset_mid();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/add_share_sched.md
# add_share_sched

Scheduler that shares one W-bit adder between two independent stream channels (ch0, ch1). Each channel has operand streams a, b and result stream s, all using the codebase stream protocol: data `_d`, end-of-stream `_e`, valid `_v`, back-pressure `_b`. The block arbitrates adder slots round-robin, buffers one result token per channel, and sequences end-of-stream per channel.

## Interface
- W, 16, operand/result data width
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- aN_d / bN_d  in  W  operand data, N∈{0,1}
- aN_e / bN_e  in  1  operand token is end-of-stream
- aN_v / bN_v  in  1  operand token valid
- aN_b / bN_b  out  1  back-pressure to operand producer (1 = not taking)
- sN_d  out  W  result data
- sN_e  out  1  result token is end-of-stream
- sN_v  out  1  result token valid
- sN_b  in  1  back-pressure from result consumer
- doneN  out  1  channel N has emitted its eos token
- mismatchN  out  1  sticky: channel N dropped tokens due to eos misalignment

## Operation
- Transfer rule: a token moves on a cycle with `_v=1` and `_b=0`. Eos tokens carry no data; `_d` is ignored when `_e=1`.
- Per-channel state: RUN, DONE. Reset → RUN.
- Per-channel 1-deep result register (full flag drives sN_v). Output slot free = register empty, or full with sN_b=0 this cycle.
- Channel N request types in RUN:
  - ADD: aN_v & bN_v & ~aN_e & ~bN_e & slot free.
  - EOS: aN_v & bN_v & aN_e & bN_e & slot free.
  - DROP: aN_v & bN_v & exactly one of aN_e/bN_e; no slot needed.
- Arbiter grants at most one channel per cycle. Single requester: granted. Both requesting: grant the channel not granted most recently. Pointer updates only on a grant; reset pointer favours ch0.
- On grant:
  - ADD: consume aN and bN; load result register with (aN_d + bN_d) mod 2^W, sN_e=0.
  - EOS: consume both; load eos token (sN_e=1, sN_d=0); state → DONE.
  - DROP: consume only the non-eos operand, discard it; set mismatchN. The eos operand is held until its partner also presents eos.
- aN_b/bN_b are combinational: 0 only for operands consumed by this cycle's grant, else 1.
- DONE: no requests; aN_b=bN_b=1; doneN=1 once the eos token leaves the register. Exit only via reset.
- Result register clears when sN_b=0 and not reloaded the same cycle; a simultaneous drain and reload keeps sN_v=1 with new data.

## Timing
- Reset values: sN_v=0, sN_e=0, sN_d=0, doneN=0, mismatchN=0, aN_b=bN_b=1 during reset cycle, pointer → ch0 first.
- Latency: grant in cycle t → sN_v=1 with result in cycle t+1.
- Throughput: one grant per cycle total; a sole active channel with sN_b=0 sustains one result per cycle.
- sN_d/sN_e stable while sN_v=1 and sN_b=1.
- Reset mid-operation: all state, buffered results, flags and pointer discarded in one cycle; no token consumed in the reset cycle.
- doneN asserts the cycle after the eos token transfers on sN.

## Test plan
- Single add: W=16, a0=0x0003, b0=0x0004, s0_b=0 → s0_d=0x0007, s0_v=1 one cycle after a0_b=b0_b=0; a0=0xFFFF, b0=0x0002 → 0x0001 (wrap).
- Contention: both channels continuously valid, s0_b=s1_b=0 → grants alternate ch0,ch1,ch0,…, ch0 first after reset; each channel one result per 2 cycles.
- Back-pressure: s0_b=1 held with result 0x0010 buffered → s0_d holds 0x0010, a0_b=b0_b=1, ch1 receives every grant; release s0_b → 0x0010 drains and a new ch0 result loads the same cycle.
- End-of-stream: both ch0 operands eos → s0_e=1, s0_v=1 next cycle; after transfer done0=1, a0_b=b0_b=1 thereafter; ch1 unaffected.
- Mismatch: a1 eos, b1 data 0x0005 then eos → b1 data consumed and dropped, mismatch1=1, then single eos emitted on s1, no data result.
- Reset mid-stream: assert reset with s0 full and ch1 mid-grant → next cycle s0_v=s1_v=0, flags 0, no operands consumed; first post-reset contention grant to ch0.
